mul16_share_ctrl: RTL and testbench

Shares one pipelined radix-4 Booth/Wallace 16x16 multiplier (`PipelinedRadix4BoothWallace16`, LAT-cycle latency) among N requesters. Arbitrates requests round-robin and drives the multiplier's operand, run and signedFlag inputs. Drains the pipeline before any change of signedness. Returns each product to its originator through a shadow pipeline that tracks the owner of every in-flight operation.

---
 rtl/mul16_share_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mul16_share_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul16_share_ctrl.sv
// Round-robin sharing of one pipelined W x W multiplier among N requesters.
// A shadow pipeline tracks the owner of every in-flight product; signedness changes drain first.
module mul16_share_ctrl #(
    parameter int unsigned N   = 2,
    parameter int unsigned W   = 16,
    parameter int unsigned LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [N*W-1:0]   req_a,
    input  logic [N*W-1:0]   req_b,
    input  logic [N-1:0]     req_signed,
    output logic [N-1:0]     rsp_valid,
    output logic [2*W-1:0]   rsp_data,
    output logic             busy,
    output logic             mul_run,
    output logic             mul_signedFlag,
    output logic [W-1:0]     mul_multiplicand,
    output logic [W-1:0]     mul_multiplier,
    input  logic [2*W-1:0]   mul_out
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(LAT + 2) + 1;

    typedef enum logic {
        StIssue = 1'b0,
        StDrain = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_ptr_next;
    logic            r_mode;
    logic            w_mode_next;
    logic            r_run;
    logic [W-1:0]    r_mcand;
    logic [W-1:0]    r_mplier;
    logic [CW-1:0]   r_inflight;
    logic [LAT:0]    r_sh_valid;
    logic [PW-1:0]   r_sh_id [LAT+1];

    logic            w_cand_found;
    logic [PW-1:0]   w_cand;
    logic [W-1:0]    w_sel_a;
    logic [W-1:0]    w_sel_b;
    logic            w_sel_signed;
    logic            w_accept;
    logic            w_rsp_fire;

    function automatic logic [PW-1:0] f_wrap(input logic [PW-1:0] base, input int unsigned offs);
        int unsigned v;
        v = 32'(base) + offs;
        if (v >= N) begin
            v = v - N;
        end
        return v[PW-1:0];
    endfunction

    // Lowest offset from the pointer wins, so scan offsets from the top down.
    always_comb begin
        w_cand_found = 1'b0;
        w_cand       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_valid[f_wrap(r_ptr, k)]) begin
                w_cand_found = 1'b1;
                w_cand       = f_wrap(r_ptr, k);
            end
        end
    end

    always_comb begin
        w_sel_a      = '0;
        w_sel_b      = '0;
        w_sel_signed = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_cand == PW'(i)) begin
                w_sel_a      = req_a[i*W +: W];
                w_sel_b      = req_b[i*W +: W];
                w_sel_signed = req_signed[i];
            end
        end
    end

    assign w_rsp_fire = r_sh_valid[LAT];

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_mode_next  = r_mode;
        w_accept     = 1'b0;
        req_ready    = '0;
        unique case (r_state)
            StIssue: begin
                if (r_run && w_cand_found) begin
                    if (w_sel_signed == r_mode) begin
                        req_ready[w_cand] = 1'b1;
                        w_accept          = 1'b1;
                        w_ptr_next        = f_wrap(w_cand, 1);
                    end else begin
                        // Park the pointer on the mismatching candidate so it is served next.
                        w_state_next = StDrain;
                        w_ptr_next   = w_cand;
                    end
                end
            end
            StDrain: begin
                // Pipeline is empty once the last response (if any) retires this cycle.
                if (r_inflight == CW'(w_rsp_fire)) begin
                    w_mode_next  = ~r_mode;
                    w_state_next = StIssue;
                end
            end
            default: w_state_next = StIssue;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIssue;
            r_ptr      <= '0;
            r_mode     <= 1'b0;
            r_run      <= 1'b0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_inflight <= '0;
            r_sh_valid <= '0;
            for (int k = 0; k <= LAT; k++) begin
                r_sh_id[k] <= '0;
            end
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_mode     <= w_mode_next;
            r_run      <= 1'b1;
            r_mcand    <= w_accept ? w_sel_a : '0;
            r_mplier   <= w_accept ? w_sel_b : '0;
            r_inflight <= r_inflight + CW'(w_accept) - CW'(w_rsp_fire);
            r_sh_valid <= {r_sh_valid[LAT-1:0], w_accept};
            r_sh_id[0] <= w_cand;
            for (int k = 1; k <= LAT; k++) begin
                r_sh_id[k] <= r_sh_id[k-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (w_rsp_fire) begin
            rsp_valid[r_sh_id[LAT]] = 1'b1;
            rsp_data                = mul_out;
        end
    end

    assign busy             = (r_inflight != '0) || (r_state == StDrain);
    assign mul_run          = r_run;
    assign mul_signedFlag   = r_mode;
    assign mul_multiplicand = r_mcand;
    assign mul_multiplier   = r_mplier;

endmodule

// File: tb/tb_mul16_share_ctrl.sv
// Bench for mul16_share_ctrl: behavioural multiplier, scoreboard of owner/product per accept,
// directed scenarios followed by random mixed-signedness traffic on four requesters.
module tb_mul16_share_ctrl;

    localparam int N     = 4;
    localparam int W     = 16;
    localparam int LAT   = 4;
    localparam int BOUND = N * (LAT + 2);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_signed;
    logic [N-1:0]     rsp_valid;
    logic [2*W-1:0]   rsp_data;
    logic             busy;
    logic             mul_run;
    logic             mul_signedFlag;
    logic [W-1:0]     mul_multiplicand;
    logic [W-1:0]     mul_multiplier;
    logic [2*W-1:0]   mul_out;

    always #5 clk = ~clk;

    mul16_share_ctrl #(.N(N), .W(W), .LAT(LAT)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_a            (req_a),
        .req_b            (req_b),
        .req_signed       (req_signed),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .busy             (busy),
        .mul_run          (mul_run),
        .mul_signedFlag   (mul_signedFlag),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_out          (mul_out)
    );

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
        longint pa;
        longint pb;
        longint p;
        if (s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'(a);
            pb = longint'(b);
        end
        p = pa * pb;
        return p[2*W-1:0];
    endfunction

    // Multiplier stand-in: out in cycle c is the product of the inputs seen in cycle c-LAT.
    logic [2*W-1:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= ref_mul(mul_multiplicand, mul_multiplier, mul_signedFlag);
        for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_out = mpipe[LAT-1];

    typedef struct {
        int             at;
        int             id;
        logic [2*W-1:0] data;
    } exp_t;

    exp_t           q[$];
    int             total = 0;
    int             bad = 0;
    int             cyc = 0;
    int             rst_age = 0;
    int             gnt_id;
    int             start_c [N];
    logic [N-1:0]   s_ready;
    logic [N-1:0]   s_rspv;
    logic [2*W-1:0] s_data;
    logic           s_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: sample and score at negedge, then return just after the next rising edge.
    task automatic tick();
        logic [N-1:0] ev;
        @(negedge clk);
        cyc++;
        s_ready = req_ready;
        s_rspv  = rsp_valid;
        s_data  = rsp_data;
        s_busy  = busy;
        gnt_id  = -1;
        if (rst) begin
            q.delete();
            rst_age = 0;
            chk("rst_rspv", rsp_valid, 0);
            chk("rst_ready", req_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_run", mul_run, 0);
        end else begin
            rst_age++;
            if (rst_age >= 2) chk("run", mul_run, 1);
            chk("ready_onehot", ($onehot0(req_ready) && ((req_ready & ~req_valid) == '0)), 1);
            if (q.size() > 0 && q[0].at == cyc) begin
                ev = '0;
                ev[q[0].id] = 1'b1;
                chk("rsp_owner", rsp_valid, ev);
                chk("rsp_data", rsp_data, q[0].data);
                void'(q.pop_front());
            end else begin
                chk("rsp_idle", rsp_valid, 0);
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    q.push_back('{at: cyc + 1 + LAT, id: i,
                                  data: ref_mul(req_a[i*W +: W], req_b[i*W +: W], req_signed[i])});
                    gnt_id = i;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic s);
        req_valid[i]    = 1'b1;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_signed[i]   = s;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 50 && (s_busy || q.size() != 0); k++) tick();
        chk("idle", {s_busy, 31'(q.size())}, 0);
    endtask

    task automatic wait_rsp();
        for (int k = 0; k < 12 && s_rspv == '0; k++) tick();
    endtask

    initial begin
        int t0;
        int r0_at;
        int g1;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        req_valid  = '1;
        req_a      = '0;
        req_b      = '0;
        req_signed = '0;

        // Reset: ready must stay low even with all requests present.
        repeat (3) tick();
        chk("rst_sflag", mul_signedFlag, 0);
        chk("rst_ops", {mul_multiplicand, mul_multiplier}, 0);
        req_valid = '0;
        rst = 1'b0;
        repeat (2) tick();

        // Single unsigned request, full-scale operands.
        set_req(0, 16'hFFFF, 16'hFFFF, 1'b0);
        tick();
        chk("t1_grant", gnt_id, 0);
        t0 = cyc;
        req_valid = '0;
        wait_rsp();
        chk("t1_lat", cyc - t0, 1 + LAT);
        chk("t1_owner", s_rspv, 4'b0001);
        chk("t1_data", s_data, 32'hFFFE0001);

        // Two requesters always valid: pointer sits at 1 after the single grant to 0.
        for (int k = 0; k < 8; k++) begin
            set_req(0, W'($urandom), W'($urandom), 1'b0);
            set_req(1, W'($urandom), W'($urandom), 1'b0);
            tick();
            chk("t2_alt", gnt_id, (k % 2 == 0) ? 1 : 0);
        end
        req_valid = '0;
        wait_idle();

        // Unsigned then signed back-to-back: drain until the unsigned result retires.
        set_req(0, 16'h8000, 16'h0002, 1'b0);
        tick();
        chk("t3_g0", gnt_id, 0);
        t0 = cyc;
        req_valid = '0;
        set_req(1, 16'h8000, 16'h0002, 1'b1);
        r0_at = -1;
        g1 = -1;
        for (int k = 0; k < 20 && g1 < 0; k++) begin
            tick();
            if (s_rspv[0]) begin
                r0_at = cyc;
                chk("t3_d0", s_data, 32'h00010000);
            end
            if (gnt_id == 1) begin
                g1 = cyc;
            end else begin
                chk("t3_no_gnt", s_ready, 0);
                chk("t3_busy", s_busy, 1);
            end
        end
        req_valid = '0;
        chk("t3_r0_at", r0_at, t0 + 1 + LAT);
        chk("t3_g1_at", g1, r0_at + 1);
        wait_rsp();
        chk("t3_owner1", s_rspv, 4'b0010);
        chk("t3_d1", s_data, 32'hFFFF0000);
        chk("t3_sflag", mul_signedFlag, 1);
        wait_idle();

        // Mismatch on an idle pipeline: one ISSUE cycle, one DRAIN cycle, then grant.
        set_req(0, W'($urandom), W'($urandom), 1'b0);
        tick();
        chk("t4_c0", {s_ready, s_busy}, 0);
        tick();
        chk("t4_c1_ready", s_ready, 0);
        chk("t4_c1_busy", s_busy, 1);
        tick();
        chk("t4_c2_grant", gnt_id, 0);
        req_valid = '0;
        wait_idle();

        // Reset with three operations in flight.
        set_req(0, W'($urandom), W'($urandom), 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_pre", gnt_id, 0);
        end
        rst = 1'b1;
        req_valid = '0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("t5_busy", s_busy, 0);
        ra = W'($urandom);
        rb = W'($urandom);
        set_req(1, ra, rb, 1'b0);
        tick();
        chk("t5_grant", gnt_id, 1);
        req_valid = '0;
        wait_rsp();
        chk("t5_owner", s_rspv, 4'b0010);
        chk("t5_data", s_data, ref_mul(ra, rb, 1'b0));
        wait_idle();

        // Random traffic, requests held until granted.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
                    start_c[i] = cyc + 1;
                end
            end
            tick();
            if (gnt_id >= 0) begin
                chk("starve", (cyc - start_c[gnt_id] <= BOUND) ? 1 : 0, 1);
                req_valid[gnt_id] = 1'b0;
            end
        end
        for (int k = 0; k < 4 * BOUND && req_valid != '0; k++) begin
            tick();
            if (gnt_id >= 0) begin
                chk("starve_tail", (cyc - start_c[gnt_id] <= BOUND) ? 1 : 0, 1);
                req_valid[gnt_id] = 1'b0;
            end
        end
        chk("all_granted", req_valid, 0);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
